// File: rtl/tensor_dump_pkg.sv
// Shared types and constants for the tensor dump streamer.
// The header states exist only when TENSOR_DUMP_HEADER_EN is defined.
package tensor_dump_pkg;

   localparam int unsigned BYTE_W = 8;
   localparam int unsigned WORD_W = 16;

   localparam logic [BYTE_W-1:0] HDR_SYNC = 8'hA5;

`ifdef TENSOR_DUMP_HEADER_EN
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR0,
      ST_HDR1,
      ST_LOAD,
      ST_SEND_HI,
      ST_SEND_LO
   } state_e;
`else
   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SEND_HI,
      ST_SEND_LO
   } state_e;
`endif

endpackage

// File: rtl/tensor_dump.sv
// Streams LENGTH 16-bit words from a kernel read port as big-endian bytes over a
// valid/ready handshake. Define TENSOR_DUMP_HEADER_EN to prefix each dump with A5, LENGTH[7:0].
module tensor_dump
   import tensor_dump_pkg::*;
#(
   parameter int unsigned TENSOR_ID = 0,
   parameter int unsigned LENGTH    = 4
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              start,
   output logic [WORD_W-1:0] read_tensor_id,
   output logic [WORD_W-1:0] read_index,
   input  logic [WORD_W-1:0] read_data,
   output logic [BYTE_W-1:0] byte_out,
   output logic              byte_valid,
   input  logic              byte_ready,
   output logic              busy,
   output logic              done
);

   localparam logic [WORD_W-1:0] LAST_IDX = WORD_W'(LENGTH - 1);
`ifdef TENSOR_DUMP_HEADER_EN
   localparam logic [BYTE_W-1:0] LEN_LO = BYTE_W'(LENGTH);
`endif

   state_e            state_q, state_d;
   logic [WORD_W-1:0] index_q, index_d;
   logic [WORD_W-1:0] word_q, word_d;
   logic [BYTE_W-1:0] byte_q, byte_d;
   logic              valid_q, valid_d;
   logic              done_q, done_d;
   logic              xfer;

   assign xfer           = valid_q & byte_ready;
   assign read_tensor_id = WORD_W'(TENSOR_ID);
   assign read_index     = index_q;
   assign byte_out       = byte_q;
   assign byte_valid     = valid_q;
   assign busy           = (state_q != ST_IDLE);
   assign done           = done_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         index_q <= '0;
         word_q  <= '0;
         byte_q  <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         index_q <= index_d;
         word_q  <= word_d;
         byte_q  <= byte_d;
         valid_q <= valid_d;
         done_q  <= done_d;
      end
   end

   // byte_out/byte_valid are computed one state ahead so they leave as registers.
   always_comb begin
      state_d = state_q;
      index_d = index_q;
      word_d  = word_q;
      byte_d  = byte_q;
      valid_d = valid_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               index_d = '0;
`ifdef TENSOR_DUMP_HEADER_EN
               state_d = ST_HDR0;
               byte_d  = HDR_SYNC;
               valid_d = 1'b1;
`else
               state_d = ST_LOAD;
`endif
            end
         end
`ifdef TENSOR_DUMP_HEADER_EN
         ST_HDR0: begin
            if (xfer) begin
               state_d = ST_HDR1;
               byte_d  = LEN_LO;
            end
         end
         ST_HDR1: begin
            if (xfer) begin
               state_d = ST_LOAD;
               valid_d = 1'b0;
            end
         end
`endif
         ST_LOAD: begin
            word_d  = read_data;
            byte_d  = read_data[WORD_W-1:BYTE_W];
            valid_d = 1'b1;
            state_d = ST_SEND_HI;
         end
         ST_SEND_HI: begin
            if (xfer) begin
               byte_d  = word_q[BYTE_W-1:0];
               state_d = ST_SEND_LO;
            end
         end
         ST_SEND_LO: begin
            if (xfer) begin
               valid_d = 1'b0;
               if (index_q == LAST_IDX) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end else begin
                  index_d = index_q + 16'd1;
                  state_d = ST_LOAD;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

endmodule

// File: doc/tensor_dump.md
TENSOR_DUMP -- requirements
Module: tensor_dump

Interface
REQ-001 SHALL have parameter TENSOR_ID, default 0, tensor id driven on read_tensor_id.
REQ-002 SHALL have parameter LENGTH, default 4, number of 16-bit words streamed per dump (1..65535).
REQ-003 SHALL have port clock  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  dump request; sampled only in IDLE.
REQ-006 SHALL have port read_tensor_id  output  16  tensor select to kernel read port.
REQ-007 SHALL have port read_index  output  16  word index to kernel read port.
REQ-008 SHALL have port read_data  input  16  word returned combinationally, same cycle as read_index.
REQ-009 SHALL have port byte_out  output  8  streamed byte.
REQ-010 SHALL have port byte_valid  output  1  byte_out holds a byte.
REQ-011 SHALL have port byte_ready  input  1  sink accepts; transfer when byte_valid & byte_ready.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port done  output  1  one-cycle pulse after final byte transfer.

Function
REQ-014 SHALL drive read_tensor_id = TENSOR_ID constantly and read_index = index register (16-bit).
REQ-015 SHALL implement FSM IDLE, LOAD, SEND_HI, SEND_LO (plus HDR0, HDR1 per REQ-026).
REQ-016 IDLE: on start=1, index<=0, go LOAD (or HDR0 if configured); otherwise stay; start while busy SHALL be ignored.
REQ-017 LOAD: word register <= read_data; go SEND_HI; byte_valid=0 in LOAD.
REQ-018 SEND_HI: byte_valid=1, byte_out=word[15:8]; on transfer go SEND_LO.
REQ-019 SEND_LO: byte_valid=1, byte_out=word[7:0]; on transfer, if index==LENGTH-1 go IDLE and assert done next cycle, else index<=index+1, go LOAD.
REQ-020 byte_out and byte_valid SHALL be registered and held stable while byte_valid=1 and byte_ready=0; byte_valid SHALL never drop without a transfer.
REQ-021 Throughput: 3 cycles per word with byte_ready held high; first byte_valid 2 cycles after start sampled (no header).
REQ-022 done SHALL pulse exactly once per dump, coincident with first IDLE cycle; start in that cycle SHALL begin a new dump.
REQ-023 read_index SHALL never exceed LENGTH-1; no wrap-around.

Reset
REQ-024 reset_n=0 SHALL immediately force IDLE, index=0, word=0, byte_out=0, byte_valid=0, done=0, busy=0, including mid-dump; no partial dump resumes.
REQ-025 After reset release, first action SHALL be on first clock edge with start=1.

Configuration
REQ-026 With TENSOR_DUMP_HEADER_EN defined, each dump SHALL be prefixed by bytes 0xA5 (HDR0) then LENGTH[7:0] (HDR1) under same handshake, IDLE->HDR0->HDR1->LOAD; without it, IDLE->LOAD and no header states exist.

Structure
REQ-027 Shared package SHALL hold FSM state enum, header sync constant 0xA5, byte and word width constants.
REQ-028 SHALL be a single module; no sub-module.

Verification
REQ-029 Model read port with words 0x1600,0x1C00,0x3100,0x4000, LENGTH=4, ready=1, pulse start -> bytes 16 00 1C 00 31 00 40 00, done once, 12 busy cycles.
REQ-030 Same stimulus, byte_ready toggled 1/0 each cycle -> identical byte sequence, byte_out stable whenever valid and not ready.
REQ-031 Assert reset_n=0 after third byte transferred -> outputs zero immediately; new start -> stream restarts from 0x16.
REQ-032 Hold start=1 throughout -> back-to-back dumps, done pulse between, second dump begins in done cycle.
REQ-033 TENSOR_DUMP_HEADER_EN defined, LENGTH=4 -> stream A5 04 16 00 1C 00 31 00 40 00.
REQ-034 LENGTH=1, word 0xBEEF -> bytes BE EF, read_index stays 0, done after second byte.
